// File: rtl/shift_pkg.sv
// Shared encodings for the shifter datapath: shift direction and deserializer FSM states.
package shift_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for the deserializer: counts accepted bits, wraps to 0 after the last bit of a word.
module ser_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first into a
// one-entry valid/ready output buffer with a sticky overflow flag.
module serial_deserializer
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             DIR,
  input  logic             SIN,
  input  logic             SIN_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             OVERFLOW
);

  state_t             state, state_next;
  logic               dir_q;
  logic               dir_eff;
  logic [WIDTH-1:0]   sreg, sreg_next;
  logic               cnt_last;
  logic               word_done;

  // Direction is taken live on the first bit and from the latched copy for the rest of the word.
  assign dir_eff   = (state == ST_IDLE) ? DIR : dir_q;
  assign sreg_next = (dir_eff == DIR_LSB_FIRST) ? {SIN, sreg[WIDTH-1:1]}
                                                : {sreg[WIDTH-2:0], SIN};
  assign word_done = SIN_VALID && (state == ST_RECV) && cnt_last;

  assign BUSY = (state == ST_RECV);

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (CLR),
    .inc  (SIN_VALID && !CLR),
    .cnt  (BIT_CNT),
    .last (cnt_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (SIN_VALID) state_next = ST_RECV;
      ST_RECV: if (word_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (CLR) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_q     <= DIR_MSB_FIRST;
      sreg      <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else if (CLR) begin
      dir_q     <= DIR_MSB_FIRST;
      sreg      <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (SIN_VALID) begin
        sreg <= sreg_next;
        if (state == ST_IDLE) dir_q <= DIR;
      end
      // A full buffer that is also being drained this cycle takes the new word with no bubble.
      if (word_done) begin
        if (!OUT_VALID || OUT_READY) begin
          OUT       <= sreg_next;
          OUT_VALID <= 1'b1;
        end else begin
          OVERFLOW  <= 1'b1;
        end
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer (WIDTH=8): vector table plus corner-case sequences.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  logic             CLK = 1'b0;
  logic             RST, CLR, DIR, SIN, SIN_VALID, OUT_READY;
  logic [WIDTH-1:0] OUT;
  logic             OUT_VALID, BUSY, OVERFLOW;
  logic [CNT_W-1:0] BIT_CNT;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       dir;
    logic [7:0] seq;     // bits in transmission order, seq[7] sent first
    logic       toggle;  // flip DIR after the first bit
    logic       gaps;    // random 0-3 idle cycles between bits
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .DIR       (DIR),
    .SIN       (SIN),
    .SIN_VALID (SIN_VALID),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY),
    .BIT_CNT   (BIT_CNT),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are set at a falling edge; one step passes a rising edge and lands on the next falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " OUT"},       32'(OUT),       32'h0);
    check({tag, " OUT_VALID"}, 32'(OUT_VALID), 32'h0);
    check({tag, " BUSY"},      32'(BUSY),      32'h0);
    check({tag, " BIT_CNT"},   32'(BIT_CNT),   32'h0);
    check({tag, " OVERFLOW"},  32'(OVERFLOW),  32'h0);
  endtask

  task automatic send_word(input logic dir, input logic [7:0] seq, input logic toggle, input logic gaps);
    int ngap;
    DIR = dir;
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        ngap = $urandom_range(0, 3);
        SIN_VALID = 1'b0;
        for (int g = 0; g < ngap; g++) begin
          step();
          check("gap BIT_CNT hold", 32'(BIT_CNT), i);
          check("gap BUSY",         32'(BUSY),    32'h1);
        end
      end
      SIN       = seq[7-i];
      SIN_VALID = 1'b1;
      step();
      if (toggle && i == 0) DIR = ~dir;
      if (i < 7) begin
        check("bit BIT_CNT", 32'(BIT_CNT), i + 1);
        check("bit BUSY",    32'(BUSY),    32'h1);
      end else begin
        check("done BIT_CNT", 32'(BIT_CNT), 32'h0);
        check("done BUSY",    32'(BUSY),    32'h0);
      end
    end
    SIN_VALID = 1'b0;
  endtask

  initial begin
    vecs[0] = '{dir: 1'b0, seq: 8'hB2, toggle: 1'b0, gaps: 1'b0, exp: 8'hB2};
    vecs[1] = '{dir: 1'b1, seq: 8'hB2, toggle: 1'b0, gaps: 1'b0, exp: 8'h4D};
    vecs[2] = '{dir: 1'b1, seq: 8'hB2, toggle: 1'b1, gaps: 1'b0, exp: 8'h4D};
    vecs[3] = '{dir: 1'b0, seq: 8'hB2, toggle: 1'b0, gaps: 1'b1, exp: 8'hB2};
    vecs[4] = '{dir: 1'b0, seq: 8'hB2, toggle: 1'b1, gaps: 1'b1, exp: 8'hB2};
    vecs[5] = '{dir: 1'b1, seq: 8'h01, toggle: 1'b0, gaps: 1'b0, exp: 8'h80};
    vecs[6] = '{dir: 1'b0, seq: 8'h01, toggle: 1'b0, gaps: 1'b1, exp: 8'h01};

    RST = 1'b1; CLR = 1'b0; DIR = 1'b0; SIN = 1'b0; SIN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
    check_zero("reset");
    RST = 1'b0;
    step();

    // Table: single words, handshake pulse of exactly one cycle.
    for (int v = 0; v < 7; v++) begin
      OUT_READY = 1'b1;
      send_word(vecs[v].dir, vecs[v].seq, vecs[v].toggle, vecs[v].gaps);
      check($sformatf("vec%0d OUT", v),       32'(OUT),       32'(vecs[v].exp));
      check($sformatf("vec%0d OUT_VALID", v), 32'(OUT_VALID), 32'h1);
      step();
      check($sformatf("vec%0d OUT_VALID drop", v), 32'(OUT_VALID), 32'h0);
      check($sformatf("vec%0d OUT hold", v),       32'(OUT),       32'(vecs[v].exp));
    end

    // Overflow: second word dropped while the buffer is full and not drained.
    OUT_READY = 1'b0;
    send_word(1'b0, 8'hB2, 1'b0, 1'b0);
    check("ovf first OUT",       32'(OUT),       32'hB2);
    check("ovf first OUT_VALID", 32'(OUT_VALID), 32'h1);
    check("ovf first OVERFLOW",  32'(OVERFLOW),  32'h0);
    send_word(1'b0, 8'h0F, 1'b0, 1'b0);
    check("ovf OUT kept",  32'(OUT),       32'hB2);
    check("ovf OUT_VALID", 32'(OUT_VALID), 32'h1);
    check("ovf OVERFLOW",  32'(OVERFLOW),  32'h1);
    OUT_READY = 1'b1;
    step();
    check("ovf drain OUT_VALID", 32'(OUT_VALID), 32'h0);
    check("ovf sticky",          32'(OVERFLOW),  32'h1);
    step(); step();
    check("ovf sticky later", 32'(OVERFLOW), 32'h1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check_zero("ovf clr");

    // Back-to-back: drained on the completion edge, no bubble.
    OUT_READY = 1'b0;
    send_word(1'b0, 8'hA5, 1'b0, 1'b0);
    check("b2b first OUT", 32'(OUT), 32'hA5);
    DIR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SIN       = 1'(8'h3C >> (7 - i));
      SIN_VALID = 1'b1;
      OUT_READY = (i == 7);
      step();
      check("b2b OUT_VALID", 32'(OUT_VALID), 32'h1);
      check("b2b OUT",       32'(OUT),       (i < 7) ? 32'hA5 : 32'h3C);
    end
    SIN_VALID = 1'b0;
    check("b2b OVERFLOW", 32'(OVERFLOW), 32'h0);
    step();
    check("b2b drain OUT_VALID", 32'(OUT_VALID), 32'h0);

    // Async reset mid-word takes effect without a clock edge.
    OUT_READY = 1'b1;
    DIR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SIN = 1'b1; SIN_VALID = 1'b1;
      step();
    end
    SIN_VALID = 1'b0;
    check("pre-rst BIT_CNT", 32'(BIT_CNT), 32'h3);
    #2 RST = 1'b1;
    #1 check_zero("async rst");
    step();
    RST = 1'b0;
    send_word(1'b0, 8'h81, 1'b0, 1'b0);
    check("post-rst OUT",       32'(OUT),       32'h81);
    check("post-rst OUT_VALID", 32'(OUT_VALID), 32'h1);
    step();

    // Synchronous clear mid-word; SIN_VALID in the clear cycle is ignored.
    for (int i = 0; i < 3; i++) begin
      SIN = 1'b0; SIN_VALID = 1'b1;
      step();
    end
    check("pre-clr BIT_CNT", 32'(BIT_CNT), 32'h3);
    CLR = 1'b1; SIN = 1'b1; SIN_VALID = 1'b1;
    step();
    CLR = 1'b0; SIN_VALID = 1'b0;
    check_zero("sync clr");
    send_word(1'b0, 8'h81, 1'b0, 1'b0);
    check("post-clr OUT",       32'(OUT),       32'h81);
    check("post-clr OUT_VALID", 32'(OUT_VALID), 32'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
